// File: rtl/armflow_sub_pkg.sv
// Shared types and widths for the sequential 49-bit minus 17-bit subtractor.
package armflow_sub_pkg;

  localparam int unsigned OPA_W  = 49;
  localparam int unsigned OPB_W  = 17;
  localparam int unsigned DIFF_W = 50;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_borrow_subtractor_chunk.sv
// Combinational CHUNK_W-bit ripple-borrow subtractor: {bout, d} = a - b - bin.
module ripple_borrow_subtractor_chunk #(
  parameter int unsigned CHUNK_W = 7
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               bin,
  output logic [CHUNK_W-1:0] d,
  output logic               bout
);

  always_comb begin : ripple
    logic br;
    br = bin;
    d  = '0;
    for (int i = 0; i < int'(CHUNK_W); i++) begin
      d[i] = a[i] ^ b[i] ^ br;
      br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/custom_subtractor49_17_seq.sv
// Multi-cycle A - {32'b0, B}, LSB-first in CHUNK_W slices (1, 7 or 49).
// Define SUB_SATURATE_EN to clamp the 49-bit result to zero on underflow.
module custom_subtractor49_17_seq
  import armflow_sub_pkg::*;
#(
  parameter int unsigned CHUNK_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPA_W-1:0]  A,
  input  logic [OPB_W-1:0]  B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIFF_W-1:0] Diff
);

  localparam int unsigned NUM_CHUNKS = OPA_W / CHUNK_W;
  localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [OPA_W-1:0]   a_sh_q, b_sh_q, res_q, res_c;
  logic               borrow_q, bout_c;
  logic [CHUNK_W-1:0] slice_c;
  logic               accept_c, last_c;
  logic [DIFF_W-1:0]  diff_c;

  assign in_ready = (state_q == IDLE);
  assign accept_c = in_valid && (state_q == IDLE);
  assign last_c   = (state_q == RUN) && (cnt_q == LAST_CNT);

  ripple_borrow_subtractor_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
    .a    (a_sh_q[CHUNK_W-1:0]),
    .b    (b_sh_q[CHUNK_W-1:0]),
    .bin  (borrow_q),
    .d    (slice_c),
    .bout (bout_c)
  );

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == DONE);
    end
  end

  // Current slice merged into the partial result
  always_comb begin
    res_c = res_q;
    res_c[cnt_q * CHUNK_W +: CHUNK_W] = slice_c;
  end

`ifdef SUB_SATURATE_EN
  assign diff_c = bout_c ? {1'b1, {OPA_W{1'b0}}} : {1'b0, res_c};
`else
  assign diff_c = {bout_c, res_c};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      Diff     <= '0;
    end else if (accept_c) begin
      a_sh_q   <= A;
      b_sh_q   <= OPA_W'(B);
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      a_sh_q   <= a_sh_q >> CHUNK_W;
      b_sh_q   <= b_sh_q >> CHUNK_W;
      res_q    <= res_c;
      borrow_q <= bout_c;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last_c) Diff <= diff_c;
    end
  end

endmodule
